// File: rtl/rs_id_allocator_pkg.sv
// Shared types for reservation-station ID handling (used by the core and the allocator).
// Provides the default RS ID width, the default pool size and the rs_id_t type.
// No logic; compile before any file that imports it.
package rs_id_allocator_pkg;

  localparam int RS_ID_WIDTH_DFLT = 5;
  localparam int RS_ID_POOL_SIZE  = 2 ** RS_ID_WIDTH_DFLT;

  typedef logic [RS_ID_WIDTH_DFLT-1:0] rs_id_t;

endpackage

// File: rtl/rs_id_allocator_lsb_enc.sv
// lowest_set_bit_encoder: reports whether any bit of 'in' is set and the index of the lowest one.
// Ports: in [WIDTH] request vector; found = |in; index = lowest set position (0 when none).
// Purely combinational, no clock, no backpressure.
module lowest_set_bit_encoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = |in;
    index = '0;
    // Scan from the top so the last hit written is the lowest set bit.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_id_allocator.sv
// rs_id_allocator: pool of reservation-station IDs; grants the lowest free ID, reclaims on write-back.
// Ports: clk, rst (async active-low); alloc_valid/alloc_ready/alloc_id (zero-latency grant);
//        release_valid/release_id (frees next edge, no bypass); free_count; release_error (sticky).
// Optional macro RS_ID_ALLOC_CHECK_EN: enables release_error and simulation assertions, else error tied 0.
module rs_id_allocator
  import rs_id_allocator_pkg::*;
#(
  parameter int RS_ID_WIDTH = RS_ID_WIDTH_DFLT,
  parameter int NUM_IDS     = 2 ** RS_ID_WIDTH,
  parameter int FIRST_ID    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  output logic [RS_ID_WIDTH-1:0] alloc_id,
  input  logic                   release_valid,
  input  logic [RS_ID_WIDTH-1:0] release_id,
  output logic [RS_ID_WIDTH:0]   free_count,
  output logic                   release_error
);

  localparam int ID_SPACE = 2 ** RS_ID_WIDTH;
  localparam int CNT_W    = RS_ID_WIDTH + 1;

  // Bits set for every allocatable ID. The mask is kept over the whole ID
  // space so any release_id can index it; bits outside FIRST_ID..NUM_IDS-1
  // are reset to 0 and can never be set, so they fold away to constants.
  function automatic logic [ID_SPACE-1:0] alloc_mask_f();
    logic [ID_SPACE-1:0] m;
    m = '0;
    for (int i = FIRST_ID; i < NUM_IDS; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [ID_SPACE-1:0] ALLOC_MASK  = alloc_mask_f();
  localparam logic [CNT_W-1:0]    FULL_COUNT  = CNT_W'(NUM_IDS - FIRST_ID);

  logic [ID_SPACE-1:0]    free_mask;
  logic [ID_SPACE-1:0]    mask_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   enc_found;
  logic [RS_ID_WIDTH-1:0] enc_index;
  logic                   grant;
  logic                   rel_eff;

  lowest_set_bit_encoder #(
    .WIDTH (ID_SPACE),
    .IDX_W (RS_ID_WIDTH)
  ) u_lsb_enc (
    .in    (free_mask),
    .found (enc_found),
    .index (enc_index)
  );

  assign alloc_ready = enc_found;
  assign alloc_id    = enc_found ? enc_index : '0;
  assign grant       = alloc_valid && alloc_ready;

  // A release only counts for an allocatable ID that is currently out.
  // Because a granted ID is free, a same-cycle release of it is never
  // effective, so grant and release never touch the same bit.
  assign rel_eff = release_valid && ALLOC_MASK[release_id] && !free_mask[release_id];

  always_comb begin
    mask_nxt  = free_mask;
    count_nxt = free_count;
    if (grant) begin
      mask_nxt[alloc_id] = 1'b0;
    end
    if (rel_eff) begin
      mask_nxt[release_id] = 1'b1;
    end
    if (grant && !rel_eff) begin
      count_nxt = free_count - CNT_W'(1);
    end else if (!grant && rel_eff) begin
      count_nxt = free_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_mask  <= ALLOC_MASK;
      free_count <= FULL_COUNT;
    end else begin
      free_mask  <= mask_nxt;
      free_count <= count_nxt;
    end
  end

`ifdef RS_ID_ALLOC_CHECK_EN
  logic rel_bad;
  logic err_q;

  // Double release, or release of a reserved / out-of-pool ID.
  assign rel_bad = release_valid && (!ALLOC_MASK[release_id] || free_mask[release_id]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (rel_bad) begin
      err_q <= 1'b1;
    end
  end

  assign release_error = err_q;

  a_grant_is_free : assert property (@(posedge clk) disable iff (!rst)
    grant |-> free_mask[alloc_id]);

  a_count_matches : assert property (@(posedge clk) disable iff (!rst)
    free_count == CNT_W'($countones(free_mask)));
`else
  assign release_error = 1'b0;
`endif

endmodule

// File: doc/rs_id_allocator.md
Name: rs_id_allocator

Overview:
- Owns the pool of reservation-station IDs handed to the dispatcher (drives id_taken) and reclaims them when the GPR write-back arbiter retires a result.
- Schedules the shared RS ID resource: hands out the lowest free ID on each dispatch handshake and frees IDs on write-back.
- Produces backpressure to dispatch when the pool is empty.

Parameters:
- RS_ID_WIDTH, 5, width of an RS ID.
- NUM_IDS, 2**RS_ID_WIDTH, pool size; IDs 0..NUM_IDS-1; must be ≤ 2**RS_ID_WIDTH.
- FIRST_ID, 0, IDs below FIRST_ID are never allocated (reserved); must be < NUM_IDS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  dispatcher requests one ID this cycle.
- alloc_ready  out  1  at least one allocatable ID is free.
- alloc_id  out  RS_ID_WIDTH  ID granted on alloc_valid && alloc_ready.
- release_valid  in  1  a result with release_id was written back this cycle.
- release_id  in  RS_ID_WIDTH  ID to return to the pool.
- free_count  out  RS_ID_WIDTH+1  number of currently free allocatable IDs.
- release_error  out  1  sticky flag; only when RS_ID_ALLOC_CHECK_EN is defined, otherwise tied 0.

Behaviour:
- State: free_mask[NUM_IDS] (1 = free) and free_count register.
- Reset (rst=0, async):
  - free_mask bits FIRST_ID..NUM_IDS-1 = 1, others 0.
  - free_count = NUM_IDS-FIRST_ID.
  - release_error = 0.
  - After reset: alloc_ready = 1, alloc_id = FIRST_ID.
- alloc_ready = |free_mask, registered state only.
- alloc_id = index of the lowest set bit of free_mask, combinational from registers. Don't-care (drive 0) when alloc_ready = 0.
- Grant = alloc_valid && alloc_ready.
  - On grant, free_mask[alloc_id] clears at the next rising edge.
  - Zero-cycle grant latency: the ID is usable by the dispatcher in the same cycle.
- alloc_valid while alloc_ready = 0: no state change, no grant. The requester holds the request; alloc_id is not sticky.
- Release: when release_valid, free_mask[release_id] sets at the next edge.
- Release of an ID < FIRST_ID or ≥ NUM_IDS is ignored.
- No bypass: an ID released in cycle N is first allocatable in cycle N+1.
  - A full pool with a release in cycle N keeps alloc_ready = 0 in cycle N.
- Simultaneous grant and release (different IDs): both apply; free_count unchanged.
- Simultaneous grant and release of the same ID is impossible, because the granted ID is free and the released ID is allocated. Under the check macro this case is a release error.
- free_count update: +1 on an effective release, −1 on grant, net 0 on both. Must always equal popcount(free_mask); it never exceeds NUM_IDS-FIRST_ID and never underflows.
- Release of an already-free ID (double release): mask unchanged; free_count unchanged.
- Reset mid-operation returns the full pool immediately. Outstanding IDs are forgotten; a later release of such an ID is a double release.
- At most one grant and one release per cycle.

Optional Feature:
- Macro RS_ID_ALLOC_CHECK_EN.
- Defined:
  - release_error sets on a release of an already-free ID, or an out-of-range/reserved ID.
  - Cleared only by reset.
  - Simulation assertions: alloc_id free when granted; free_count == popcount(free_mask) every cycle.
- Undefined: release_error tied 0; no checks; behaviour otherwise identical.

Decomposition:
- ppc_types gains rs_id_t sized by RS_ID_WIDTH default and a constant RS_ID_POOL_SIZE. The core and this block share them.
- One sub-module, lowest_set_bit_encoder:
  - parameterised width.
  - outputs found and index.
  - reused later by the write-back arbiter.

Test Plan:
- Reset, NUM_IDS=32, FIRST_ID=0 -> alloc_ready=1, alloc_id=0, free_count=32, release_error=0.
- alloc_valid held 32 cycles -> alloc_id 0,1,…,31 on consecutive cycles; then alloc_ready=0, free_count=0; a 33rd request is not granted.
- Pool full, release_id=5 in cycle N -> alloc_ready=0 in N; alloc_ready=1, alloc_id=5, free_count=1 in N+1.
- IDs 0–3 allocated; same-cycle grant (ID 4) and release_id=2 -> next cycle free_count=28, alloc_id=2.
- Check macro defined: release_id=7 while 7 free -> release_error=1 next cycle, sticky, free_count unchanged. Release_id=2 with FIRST_ID=4 -> release_error=1.
- 10 IDs allocated, rst pulsed low mid-cycle (async) -> outputs return to reset values immediately, without waiting for a clk edge.
